// File: rtl/lsu_sequencer.sv
// rtl/lsu_sequencer.sv - load/store sequencer driving the core memory bus interface stage
// Optional issue timeout enabled by defining LSU_TIMEOUT_EN.
module lsu_sequencer #(
  parameter int DataWidth     = 32,
  parameter int AddressWidth  = 32,
  parameter int TimeoutCycles = 256
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [2:0]              req_funct3,
  input  logic [AddressWidth-1:0] req_addr,
  input  logic [DataWidth-1:0]    req_wdata,
  input  logic                    flush,
  output logic                    resp_valid,
  output logic [DataWidth-1:0]    resp_rdata,
  output logic [1:0]              resp_cause,
  output logic [AddressWidth-1:0] mi_address,
  output logic [2:0]              mi_sign_size,
  output logic                    mi_rd,
  output logic                    mi_wr,
  output logic [DataWidth-1:0]    mi_data_in,
  input  logic [DataWidth-1:0]    mi_data_out,
  input  logic                    mi_malign,
  input  logic                    mi_complete_read,
  input  logic                    mi_complete_write,
  input  logic                    mi_hit
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  localparam logic [1:0] CauseOk       = 2'd0;
  localparam logic [1:0] CauseMisalign = 2'd1;
  localparam logic [1:0] CauseFault    = 2'd2;

  state_e                  state_q, state_d;
  logic                    write_q, write_d;
  logic [2:0]              funct3_q, funct3_d;
  logic [AddressWidth-1:0] addr_q, addr_d;
  logic [DataWidth-1:0]    wdata_q, wdata_d;
  logic                    resp_valid_q, resp_valid_d;
  logic [DataWidth-1:0]    resp_rdata_q, resp_rdata_d;
  logic [1:0]              resp_cause_q, resp_cause_d;

`ifdef LSU_TIMEOUT_EN
  localparam int CntW = $clog2(TimeoutCycles + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);
  localparam logic [1:0] CauseTimeout = 2'd3;

  logic [CntW-1:0] cnt_q, cnt_d;
`endif

  always_comb begin
    state_d      = state_q;
    write_d      = write_q;
    funct3_d     = funct3_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    resp_cause_d = resp_cause_q;
`ifdef LSU_TIMEOUT_EN
    cnt_d        = cnt_q;
`endif

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d  = req_write;
          funct3_d = req_funct3;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          state_d  = ISSUE;
`ifdef LSU_TIMEOUT_EN
          cnt_d    = '0;
`endif
        end
      end

      ISSUE: begin
        if (flush) begin
          state_d = IDLE;
        end else if (mi_malign) begin
          state_d      = IDLE;
          resp_valid_d = 1'b1;
          resp_cause_d = CauseMisalign;
          resp_rdata_d = '0;
        end else if (mi_complete_read || mi_complete_write) begin
          state_d = WAIT;
        end
`ifdef LSU_TIMEOUT_EN
        else if (cnt_q == CntLast) begin
          state_d      = IDLE;
          resp_valid_d = 1'b1;
          resp_cause_d = CauseTimeout;
          resp_rdata_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end

      WAIT: begin
        // The bus transfer already happened; flush here only suppresses the response.
        state_d = IDLE;
        if (!flush) begin
          resp_valid_d = 1'b1;
          resp_cause_d = mi_hit ? CauseOk : CauseFault;
          resp_rdata_d = (!write_q && mi_hit) ? mi_data_out : '0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      write_q      <= 1'b0;
      funct3_q     <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_cause_q <= '0;
    end else begin
      state_q      <= state_d;
      write_q      <= write_d;
      funct3_q     <= funct3_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_cause_q <= resp_cause_d;
    end
  end

`ifdef LSU_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  assign req_ready    = (state_q == IDLE);
  assign mi_address   = addr_q;
  assign mi_sign_size = funct3_q;
  assign mi_data_in   = wdata_q;
  assign mi_rd        = (state_q == ISSUE) && !write_q && !flush;
  assign mi_wr        = (state_q == ISSUE) && write_q && !flush;
  assign resp_valid   = resp_valid_q;
  assign resp_rdata   = resp_rdata_q;
  assign resp_cause   = resp_cause_q;

endmodule

// File: tb/tb_lsu_sequencer.sv
// tb/tb_lsu_sequencer.sv - self-checking bench for lsu_sequencer
// Honours LSU_TIMEOUT_EN to match the DUT build.
module tb_lsu_sequencer;

  localparam int TO = 4;
`ifdef LSU_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        flush;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_cause;
  logic [31:0] mi_address;
  logic [2:0]  mi_sign_size;
  logic        mi_rd, mi_wr;
  logic [31:0] mi_data_in, mi_data_out;
  logic        mi_malign, mi_complete_read, mi_complete_write, mi_hit;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Bus interface alignment rule, evaluated on what the sequencer presents.
  assign mi_malign = (mi_sign_size[1:0] == 2'd1 && mi_address[0]) ||
                     (mi_sign_size[1:0] == 2'd2 && mi_address[1:0] != 2'd0);

  lsu_sequencer #(.DataWidth(32), .AddressWidth(32), .TimeoutCycles(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .flush(flush),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_cause(resp_cause),
    .mi_address(mi_address), .mi_sign_size(mi_sign_size),
    .mi_rd(mi_rd), .mi_wr(mi_wr), .mi_data_in(mi_data_in), .mi_data_out(mi_data_out),
    .mi_malign(mi_malign), .mi_complete_read(mi_complete_read),
    .mi_complete_write(mi_complete_write), .mi_hit(mi_hit)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic quiet_inputs();
    req_valid = 1'b0;
    flush = 1'b0;
    mi_complete_read = 1'b0;
    mi_complete_write = 1'b0;
    req_write = $urandom_range(0, 1);
    req_funct3 = 3'($urandom);
    req_addr = $urandom;
    req_wdata = $urandom;
    mi_hit = $urandom_range(0, 1);
    mi_data_out = $urandom;
  endtask

  // Starts in the current cycle (low clock phase); returns positioned in the response cycle.
  task automatic run_txn(input logic w, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input int busy, input logic hit,
                         input logic [31:0] dout);
    logic mal, tmo, exp_rd, exp_wr;
    int last_issue, resp_c;
    logic [1:0] exp_cause;
    logic [31:0] exp_rdata;
    mal = (f3[1:0] == 2'd1 && a[0]) || (f3[1:0] == 2'd2 && a[1:0] != 2'd0);
    tmo = TO_EN && !mal && busy >= TO;
    if (mal) begin
      last_issue = 1; resp_c = 2; exp_cause = 2'd1; exp_rdata = 32'h0;
    end else if (tmo) begin
      last_issue = TO; resp_c = TO + 1; exp_cause = 2'd3; exp_rdata = 32'h0;
    end else begin
      last_issue = 1 + busy; resp_c = 3 + busy;
      exp_cause = hit ? 2'd0 : 2'd2;
      exp_rdata = (!w && hit) ? dout : 32'h0;
    end

    quiet_inputs();
    req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = wd;
    #1;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL accept_ready got %b want 1 addr=%h", req_ready, a);
    end
    checks++;

    for (int c = 1; c <= resp_c; c++) begin
      @(negedge clk);
      quiet_inputs();
      if (!mal && !tmo && c == 1 + busy) begin
        mi_complete_read = !w;
        mi_complete_write = w;
      end
      if (c == 2 + busy) begin
        mi_hit = hit;
        mi_data_out = dout;
      end
      #1;
      exp_rd = (c <= last_issue) && !w;
      exp_wr = (c <= last_issue) && w;
      if (mi_rd !== exp_rd || mi_wr !== exp_wr) begin
        errors++;
        $display("FAIL rd_wr c=%0d got rd=%b wr=%b want rd=%b wr=%b", c, mi_rd, mi_wr, exp_rd, exp_wr);
      end
      checks++;
      if (c <= last_issue) begin
        if (mi_address !== a || mi_data_in !== wd || mi_sign_size !== f3) begin
          errors++;
          $display("FAIL hold c=%0d got a=%h d=%h s=%0d want a=%h d=%h s=%0d",
                   c, mi_address, mi_data_in, mi_sign_size, a, wd, f3);
        end
        checks++;
      end
      if (resp_valid !== (c == resp_c) || req_ready !== (c == resp_c)) begin
        errors++;
        $display("FAIL resp_timing c=%0d got valid=%b ready=%b want %b", c, resp_valid, req_ready, c == resp_c);
      end
      checks++;
      if (c == resp_c) begin
        if (resp_cause !== exp_cause || resp_rdata !== exp_rdata) begin
          errors++;
          $display("FAIL resp_data got cause=%0d rdata=%h want cause=%0d rdata=%h",
                   resp_cause, resp_rdata, exp_cause, exp_rdata);
        end
        checks++;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    quiet_inputs();
    repeat (2) @(negedge clk);
    #1;
    if (resp_valid !== 1'b0 || resp_rdata !== 32'h0 || resp_cause !== 2'd0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_resp got v=%b d=%h c=%0d rdy=%b want 0 0 0 1", resp_valid, resp_rdata, resp_cause, req_ready);
    end
    checks++;
    if (mi_rd !== 1'b0 || mi_wr !== 1'b0 || mi_address !== 32'h0 || mi_data_in !== 32'h0 || mi_sign_size !== 3'd0) begin
      errors++;
      $display("FAIL reset_bus got rd=%b wr=%b a=%h d=%h s=%0d want all 0", mi_rd, mi_wr, mi_address, mi_data_in, mi_sign_size);
    end
    checks++;
    rst_n = 1'b1;
  endtask

  task automatic test_aligned_load();
    @(negedge clk);
    run_txn(1'b0, 3'd2, 32'h100, 32'h0, 0, 1'b1, 32'hDEADBEEF);
  endtask

  task automatic test_misaligned_store();
    @(negedge clk);
    run_txn(1'b1, 3'd1, 32'h101, 32'h1234, 0, 1'b1, 32'h0);
  endtask

  task automatic test_busy_store();
    @(negedge clk);
    run_txn(1'b1, 3'd2, 32'h200, 32'h55, 5, 1'b1, 32'h0);
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    run_txn(1'b0, 3'd2, 32'h104, 32'h0, 0, 1'b0, 32'hCAFEF00D);
    run_txn(1'b0, 3'd4, 32'h33, 32'h0, 1, 1'b1, 32'h000000A5);
  endtask

  task automatic test_flush_issue();
    logic seen;
    @(negedge clk);
    quiet_inputs();
    req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'd2; req_addr = 32'h300;
    @(negedge clk);
    quiet_inputs();
    #1;
    if (mi_rd !== 1'b1) begin
      errors++; $display("FAIL flush_issue_rd_before got %b want 1", mi_rd);
    end
    checks++;
    @(negedge clk);
    quiet_inputs();
    flush = 1'b1;
    #1;
    if (mi_rd !== 1'b0 || mi_wr !== 1'b0) begin
      errors++; $display("FAIL flush_issue_gate got rd=%b wr=%b want 0 0", mi_rd, mi_wr);
    end
    checks++;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      quiet_inputs();
      #1;
      if (resp_valid) seen = 1'b1;
    end
    if (seen !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL flush_issue_after got resp_seen=%b ready=%b want 0 1", seen, req_ready);
    end
    checks++;
  endtask

  task automatic test_flush_wait();
    logic seen;
    @(negedge clk);
    quiet_inputs();
    req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'd2; req_addr = 32'h308;
    @(negedge clk);
    quiet_inputs();
    mi_complete_read = 1'b1;
    @(negedge clk);
    quiet_inputs();
    flush = 1'b1; mi_hit = 1'b1; mi_data_out = 32'h11223344;
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      quiet_inputs();
      #1;
      if (resp_valid) seen = 1'b1;
    end
    if (seen !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL flush_wait got resp_seen=%b ready=%b want 0 1", seen, req_ready);
    end
    checks++;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    quiet_inputs();
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'd2; req_addr = 32'h400; req_wdata = 32'h77;
    @(negedge clk);
    quiet_inputs();
    #1;
    if (mi_wr !== 1'b1) begin
      errors++; $display("FAIL reset_mid_wr_before got %b want 1", mi_wr);
    end
    checks++;
    @(negedge clk);
    quiet_inputs();
    rst_n = 1'b0;
    #1;
    if (req_ready !== 1'b1 || mi_wr !== 1'b0 || mi_address !== 32'h0 || mi_data_in !== 32'h0 || resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid got rdy=%b wr=%b a=%h d=%h v=%b want 1 0 0 0 0", req_ready, mi_wr, mi_address, mi_data_in, resp_valid);
    end
    checks++;
    rst_n = 1'b1;
    // Reset landing on a pending response must drop it.
    @(negedge clk);
    quiet_inputs();
    req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'd2; req_addr = 32'h404;
    @(negedge clk);
    quiet_inputs();
    mi_complete_read = 1'b1;
    @(negedge clk);
    quiet_inputs();
    mi_hit = 1'b1;
    @(negedge clk);
    quiet_inputs();
    rst_n = 1'b0;
    #1;
    if (resp_valid !== 1'b0 || resp_rdata !== 32'h0) begin
      errors++; $display("FAIL reset_drop_resp got v=%b d=%h want 0 0", resp_valid, resp_rdata);
    end
    checks++;
    rst_n = 1'b1;
  endtask

  task automatic test_timeout();
`ifdef LSU_TIMEOUT_EN
    @(negedge clk);
    run_txn(1'b0, 3'd2, 32'h500, 32'h0, 50, 1'b1, 32'h0);
`else
    logic seen;
    @(negedge clk);
    quiet_inputs();
    req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'd2; req_addr = 32'h500;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      quiet_inputs();
      #1;
      if (resp_valid) seen = 1'b1;
    end
    if (seen !== 1'b0 || req_ready !== 1'b0 || mi_rd !== 1'b1) begin
      errors++; $display("FAIL no_timeout got resp_seen=%b ready=%b rd=%b want 0 0 1", seen, req_ready, mi_rd);
    end
    checks++;
    @(negedge clk);
    quiet_inputs();
    flush = 1'b1;
`endif
  endtask

  task automatic test_random();
    int gap;
    logic [2:0] f3;
    @(negedge clk);
    quiet_inputs();
    for (int n = 0; n < 40; n++) begin
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        quiet_inputs();
        #1;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
          errors++; $display("FAIL idle_gap got v=%b rdy=%b want 0 1", resp_valid, req_ready);
        end
        checks++;
      end
      f3 = {1'($urandom_range(0, 1)), 2'($urandom_range(0, 2))};
      run_txn(1'($urandom_range(0, 1)), f3, $urandom, $urandom, $urandom_range(0, 6),
              1'($urandom_range(0, 1)), $urandom);
    end
  endtask

  initial begin
    test_reset();
    test_aligned_load();
    test_misaligned_store();
    test_busy_store();
    test_back_to_back();
    test_flush_issue();
    test_flush_wait();
    test_reset_mid();
    test_timeout();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lsu_sequencer.md
Name: lsu_sequencer

Overview:
- Core-side load/store sequencer; sits directly upstream of the core's memory bus interface stage.
- Accepts one load/store request at a time from execute over a valid/ready handshake.
- Drives the interface's address, sign_size, rd, wr and data_in signals, holding them until the bus grants the access.
- Captures hit/read data in the response cycle and returns one registered response with an exception cause.

Parameters:
DataWidth, 32, data width; must match the bus interface data width.
AddressWidth, 32, byte address width.
TimeoutCycles, 256, maximum cycles spent in ISSUE before a timeout response; used only with LSU_TIMEOUT_EN.

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
req_valid  input  1  request present
req_ready  output  1  sequencer can accept a request
req_write  input  1  1=store, 0=load
req_funct3  input  3  bit2=unsigned, bits1:0=size (0 byte, 1 half, 2 word)
req_addr  input  AddressWidth  byte address
req_wdata  input  DataWidth  store data, right-aligned
flush  input  1  kill the in-flight request
resp_valid  output  1  one-cycle response pulse
resp_rdata  output  DataWidth  extended load data; 0 for stores and faults
resp_cause  output  2  0 ok, 1 misaligned, 2 access fault, 3 timeout
mi_address  output  AddressWidth  to interface address
mi_sign_size  output  3  to interface sign_size (= latched funct3)
mi_rd  output  1  to interface rd
mi_wr  output  1  to interface wr
mi_data_in  output  DataWidth  to interface data_in
mi_data_out  input  DataWidth  from interface data_out; valid the cycle after completion
mi_malign  input  1  from interface malign (combinational)
mi_complete_read  input  1  from interface complete_read
mi_complete_write  input  1  from interface complete_write
mi_hit  input  1  from interface hit; valid the cycle after completion

Behaviour:
- States: IDLE, ISSUE, WAIT.
- Reset (async, rst_n low): state=IDLE; request registers, resp_rdata=0, resp_cause=0, resp_valid=0, timeout counter=0.
- req_ready = (state==IDLE).
- IDLE:
  - On req_valid, latch write, funct3, addr and wdata, then go to ISSUE.
  - flush in IDLE has no effect.
- mi_address, mi_sign_size and mi_data_in always reflect the latched request registers.
- mi_rd = ISSUE && !write_q && !flush. mi_wr = ISSUE && write_q && !flush.
- ISSUE, evaluated in this priority order:
  - flush: go to IDLE, no response.
  - mi_malign: go to IDLE; next cycle resp_valid=1, cause=1. No bus access occurs.
  - mi_complete_read or mi_complete_write: go to WAIT.
  - Otherwise (bus not available): remain in ISSUE with outputs stable.
- WAIT: always go to IDLE, registering the response:
  - cause = mi_hit ? 0 : 2.
  - rdata = (load && mi_hit) ? mi_data_out : 0.
  - resp_valid=1 in the following cycle, unless flush is high in WAIT. The bus transfer has already happened; the response is then suppressed.
- resp_valid is a one-cycle pulse, coincident with state IDLE. A new request may be accepted in the same cycle as resp_valid (back-to-back).
- Latency with the bus available:
  - Accept at cycle 0; mi_rd/mi_wr high and completion at cycle 1; WAIT at cycle 2; resp_valid at cycle 3.
  - A misaligned request gets resp_valid at cycle 2.
- Throughput: one access per 3 cycles.
- Reset asserted mid-operation: state returns to IDLE immediately and any pending resp_valid is dropped.

Optional Feature:
LSU_TIMEOUT_EN
- Defined:
  - A counter of width $clog2(TimeoutCycles+1) clears on entering ISSUE and increments each ISSUE cycle without completion, malign or flush.
  - When the counter reaches TimeoutCycles-1 while still uncompleted: go to IDLE, resp_valid next cycle, cause=3, rdata=0.
  - flush and malign take priority over timeout.
- Undefined: no counter; ISSUE waits indefinitely; cause 3 is never produced.

Test Plan:
- Aligned word load: addr 0x100, funct3=2, bus available, mi_hit=1, mi_data_out=0xDEADBEEF -> mi_rd high cycle 1 only; resp_valid cycle 3, rdata 0xDEADBEEF, cause 0.
- Misaligned half store: addr 0x101, funct3=1, mi_malign=1 -> mi_wr gated to no completion; resp_valid cycle 2, cause 1, rdata 0.
- Bus busy for 5 cycles (no completion) then available on a store to 0x200 with wdata 0x55 -> mi_address=0x200 and mi_data_in=0x55 held stable throughout; resp_valid 2 cycles after completion, cause 0.
- Load with mi_hit=0 at the response cycle -> cause 2, rdata 0; req_ready high on the resp_valid cycle; a second request accepted in that cycle completes normally.
- flush during ISSUE while the bus is busy -> no mi_rd/mi_wr in the flush cycle, no resp_valid, back to IDLE. flush during WAIT -> no resp_valid. rst_n pulsed low mid-ISSUE -> IDLE with all outputs 0.
- With LSU_TIMEOUT_EN and TimeoutCycles=4, bus never available -> resp_valid 5 cycles after acceptance, cause 3. Without the macro -> still in ISSUE after 100 cycles.
